// File: rtl/ddr_rd_arb.sv
// ddr_rd_arb: round-robin arbiter sharing one DDR AXI read port among NUM_REQ requesters
module ddr_rd_arb #(
    parameter int NUM_REQ   = 4,
    parameter int OST_DEPTH = 16
) (
    input  logic                           user_clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             s_arvalid,
    input  logic [NUM_REQ*64-1:0]          s_araddr,
    input  logic [NUM_REQ*8-1:0]           s_arlen,
    output logic [NUM_REQ-1:0]             s_arready,
    output logic [NUM_REQ-1:0]             s_rvalid,
    output logic [511:0]                   s_rdata,
    output logic                           s_rlast,
    output logic [1:0]                     s_rresp,
    input  logic [NUM_REQ-1:0]             s_rready,
    output logic                           m_axi_cu_arvalid,
    output logic [63:0]                    m_axi_cu_araddr,
    output logic [7:0]                     m_axi_cu_arlen,
    input  logic                           m_axi_cu_arready,
    input  logic                           m_axi_cu_rvalid,
    input  logic [511:0]                   m_axi_cu_rdata,
    input  logic                           m_axi_cu_rlast,
    input  logic [1:0]                     m_axi_cu_rresp,
    output logic                           m_axi_cu_rready,
    output logic [$clog2(OST_DEPTH):0]     ost_cnt
);
    localparam int CW = $clog2(OST_DEPTH) + 1;
    localparam int PW = $clog2(OST_DEPTH);
    localparam int IW = $clog2(NUM_REQ);

    logic          ar_valid_q, ar_valid_d;
    logic [63:0]   ar_addr_q, ar_addr_d;
    logic [7:0]    ar_len_q, ar_len_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] fifo_q [OST_DEPTH];
    logic          load_en, found, grant, empty, pop;
    logic [IW-1:0] win, head;

    // rotating search for the first valid requester after the last winner
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && s_arvalid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // grant, R routing by FIFO head, and next-state computation
    always_comb begin
        load_en         = ~ar_valid_q | m_axi_cu_arready;
        grant           = reset_n & load_en & found & (cnt_q < CW'(OST_DEPTH));
        s_arready       = grant ? NUM_REQ'(1) << win : '0;
        empty           = cnt_q == '0;
        head            = fifo_q[rd_ptr_q];
        s_rvalid        = (m_axi_cu_rvalid & ~empty) ? NUM_REQ'(1) << head : '0;
        m_axi_cu_rready = s_rready[head] & ~empty;
        pop             = m_axi_cu_rvalid & m_axi_cu_rready & m_axi_cu_rlast;
        ar_valid_d      = load_en ? grant : ar_valid_q;
        ar_addr_d       = grant ? s_araddr[int'(win)*64 +: 64] : ar_addr_q;
        ar_len_d        = grant ? s_arlen[int'(win)*8 +: 8] : ar_len_q;
        rr_ptr_d        = grant ? win : rr_ptr_q;
        wr_ptr_d        = wr_ptr_q + PW'(grant);
        rd_ptr_d        = rd_ptr_q + PW'(pop);
        cnt_d           = cnt_q + CW'(grant) - CW'(pop);
    end

    // state registers; the ID FIFO records grant order for R return routing
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < OST_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            if (grant) fifo_q[wr_ptr_q] <= win;
        end
    end

    assign m_axi_cu_arvalid = ar_valid_q;
    assign m_axi_cu_araddr  = ar_addr_q;
    assign m_axi_cu_arlen   = ar_len_q;
    assign s_rdata          = m_axi_cu_rdata;
    assign s_rlast          = m_axi_cu_rlast;
    assign s_rresp          = m_axi_cu_rresp;
    assign ost_cnt          = cnt_q;
endmodule

// File: tb/tb_ddr_rd_arb.sv
// tb_ddr_rd_arb: directed and random checks of ddr_rd_arb against a queue-based reference model
module tb_ddr_rd_arb;
    localparam int N = 4;
    localparam int D = 16;

    logic              user_clk = 1'b0;
    logic              reset_n  = 1'b0;
    logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*64-1:0]   s_araddr;
    logic [N*8-1:0]    s_arlen;
    logic [511:0]      s_rdata;
    logic              s_rlast;
    logic [1:0]        s_rresp;
    logic              m_axi_cu_arvalid, m_axi_cu_arready;
    logic [63:0]       m_axi_cu_araddr;
    logic [7:0]        m_axi_cu_arlen;
    logic              m_axi_cu_rvalid, m_axi_cu_rlast, m_axi_cu_rready;
    logic [511:0]      m_axi_cu_rdata;
    logic [1:0]        m_axi_cu_rresp;
    logic [$clog2(D):0] ost_cnt;

    ddr_rd_arb #(.NUM_REQ(N), .OST_DEPTH(D)) dut (
        .user_clk(user_clk), .reset_n(reset_n),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rresp(s_rresp), .s_rready(s_rready),
        .m_axi_cu_arvalid(m_axi_cu_arvalid), .m_axi_cu_araddr(m_axi_cu_araddr), .m_axi_cu_arlen(m_axi_cu_arlen),
        .m_axi_cu_arready(m_axi_cu_arready), .m_axi_cu_rvalid(m_axi_cu_rvalid), .m_axi_cu_rdata(m_axi_cu_rdata),
        .m_axi_cu_rlast(m_axi_cu_rlast), .m_axi_cu_rresp(m_axi_cu_rresp), .m_axi_cu_rready(m_axi_cu_rready),
        .ost_cnt(ost_cnt)
    );

    always #5 user_clk = ~user_clk;

    int total = 0;
    int bad   = 0;
    // reference model: grant order, requests accepted by memory, beat position, round-robin pointer
    int owners[$];
    int mem_len[$];
    int beat, rr, exp_win, len_max, obs3;
    bit exp_gnt, rnd, r_en, r_hold;
    logic         mar_v;
    logic [63:0]  mar_a;
    logic [7:0]   mar_l;
    logic [N-1:0] keep;
    logic [N-1:0] gnt_log[$];

    initial begin
        #1ms;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owners.delete();
        mem_len.delete();
        beat  = 0;
        rr    = N - 1;
        mar_v = 1'b0;
        mar_a = '0;
        mar_l = '0;
    endtask

    task automatic new_req(input int i);
        s_arvalid[i]          = 1'b1;
        s_araddr[64*i +: 64]  = {$urandom, $urandom};
        s_arlen[8*i +: 8]     = 8'($urandom_range(0, len_max));
    endtask

    task automatic drive_r();
        if (r_en && mem_len.size() > 0) begin
            m_axi_cu_rvalid = 1'b1;
            m_axi_cu_rlast  = (beat == mem_len[0]);
            m_axi_cu_rresp  = 2'($urandom);
            for (int w = 0; w < 16; w++) m_axi_cu_rdata[32*w +: 32] = $urandom;
        end else begin
            m_axi_cu_rvalid = 1'b0;
            m_axi_cu_rlast  = 1'b0;
        end
    endtask

    // spec rule: first valid requester after rr, if the AR slot can load and fewer than D are outstanding
    task automatic predict();
        bit ld;
        ld      = !mar_v || m_axi_cu_arready;
        exp_gnt = 1'b0;
        exp_win = 0;
        if (ld && owners.size() < D)
            for (int k = 1; k <= N; k++)
                if (!exp_gnt && s_arvalid[(rr + k) % N]) begin
                    exp_gnt = 1'b1;
                    exp_win = (rr + k) % N;
                end
    endtask

    task automatic cycle();
        logic [N-1:0] ea, ev;
        bit er, ld;
        int h;
        @(negedge user_clk);
        predict();
        h  = owners.size() > 0 ? owners[0] : 0;
        ea = exp_gnt ? N'(1) << exp_win : '0;
        ev = (m_axi_cu_rvalid && owners.size() > 0) ? N'(1) << h : '0;
        er = owners.size() > 0 && s_rready[h];
        gnt_log.push_back(s_arready);
        if (s_rvalid[3] && s_rready[3]) obs3++;
        chk("s_arready", 512'(s_arready), 512'(ea));
        chk("m_arvalid", 512'(m_axi_cu_arvalid), 512'(mar_v));
        chk("m_araddr", 512'(m_axi_cu_araddr), 512'(mar_a));
        chk("m_arlen", 512'(m_axi_cu_arlen), 512'(mar_l));
        chk("s_rvalid", 512'(s_rvalid), 512'(ev));
        chk("m_rready", 512'(m_axi_cu_rready), 512'(er));
        chk("ost_cnt", 512'(ost_cnt), 512'(owners.size()));
        chk("s_rdata", s_rdata, m_axi_cu_rdata);
        chk("s_rlast", 512'(s_rlast), 512'(m_axi_cu_rlast));
        chk("s_rresp", 512'(s_rresp), 512'(m_axi_cu_rresp));
        @(posedge user_clk);
        ld = !mar_v || m_axi_cu_arready;
        if (mar_v && m_axi_cu_arready) mem_len.push_back(int'(mar_l));
        if (m_axi_cu_rvalid && er) begin
            if (m_axi_cu_rlast) begin
                void'(owners.pop_front());
                if (mem_len.size() > 0) void'(mem_len.pop_front());
                beat = 0;
            end else beat++;
        end
        if (exp_gnt) begin
            owners.push_back(exp_win);
            rr    = exp_win;
            mar_v = 1'b1;
            mar_a = s_araddr[64*exp_win +: 64];
            mar_l = s_arlen[8*exp_win +: 8];
        end else if (ld) mar_v = 1'b0;
        #1;
        if (exp_gnt) begin
            if (keep[exp_win]) new_req(exp_win);
            else s_arvalid[exp_win] = 1'b0;
        end
        if (rnd) begin
            m_axi_cu_arready = 1'($urandom);
            s_rready         = N'($urandom);
            keep             = N'($urandom);
            r_en             = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) if (!s_arvalid[i] && ($urandom % 3) == 0) new_req(i);
        end
        if (!r_hold) drive_r();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rnd = 1'b0; keep = '0; r_en = 1'b1; r_hold = 1'b0;
        m_axi_cu_arready = 1'b1;
        s_rready = '1;
        drive_r();
        while ((owners.size() > 0 || mar_v || mem_len.size() > 0 || s_arvalid != '0) && n < 600) begin
            cycle();
            n++;
        end
        chk("drain_done", 512'(n < 600), 512'(1));
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '1;
        m_axi_cu_arready = 1'b1; m_axi_cu_rvalid = 1'b0; m_axi_cu_rlast = 1'b0;
        m_axi_cu_rdata = '0; m_axi_cu_rresp = '0;
        rnd = 1'b0; r_en = 1'b0; r_hold = 1'b0; keep = '0;
        model_reset();
        @(posedge user_clk);
        @(posedge user_clk);
        #1;
        chk("rst_arvalid", 512'(m_axi_cu_arvalid), 512'(0));
        chk("rst_araddr", 512'(m_axi_cu_araddr), 512'(0));
        chk("rst_ost", 512'(ost_cnt), 512'(0));
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [5];
        logic [63:0]  a1, a2;
        int n, o3;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        len_max = 7;
        obs3 = 0;
        reset_dut();

        // single burst from requester 0
        s_arvalid[0] = 1'b1;
        s_araddr[63:0] = 64'h1000;
        s_arlen[7:0] = 8'd3;
        cycle();
        chk("single_arvalid", 512'(m_axi_cu_arvalid), 512'(1));
        chk("single_araddr", 512'(m_axi_cu_araddr), 512'(64'h1000));
        chk("single_arlen", 512'(m_axi_cu_arlen), 512'(3));
        chk("single_ost1", 512'(ost_cnt), 512'(1));
        r_en = 1'b1;
        repeat (8) cycle();
        chk("single_ost0", 512'(ost_cnt), 512'(0));

        // round robin from reset with all requesters valid
        reset_dut();
        len_max = 0;
        keep = '1;
        for (int i = 0; i < N; i++) new_req(i);
        gnt_log.delete();
        repeat (5) cycle();
        for (int k = 0; k < 5; k++) chk("rr_order", 512'(gnt_log[k]), 512'(rr_exp[k]));
        s_arvalid = '0;
        drain();

        // full FIFO: no R responses, all requesters keep requesting
        r_en = 1'b0;
        keep = '1;
        for (int i = 0; i < N; i++) new_req(i);
        drive_r();
        repeat (20) cycle();
        chk("full_ost", 512'(ost_cnt), 512'(D));
        chk("full_block", 512'(s_arready), 512'(0));
        r_en = 1'b1;
        drive_r();
        r_en = 1'b0;
        cycle();
        chk("full_pop_ost", 512'(ost_cnt), 512'(D - 1));
        chk("full_regrant", 512'(s_arready != '0), 512'(1));
        cycle();
        chk("full_again", 512'(ost_cnt), 512'(D));
        s_arvalid = '0;
        drain();

        // AR backpressure with two requesters
        len_max = 3;
        m_axi_cu_arready = 1'b0;
        new_req(1);
        new_req(2);
        a1 = s_araddr[127:64];
        a2 = s_araddr[191:128];
        cycle();
        chk("bp_first", 512'(m_axi_cu_araddr), 512'(owners[owners.size()-1] == 1 ? a1 : a2));
        repeat (5) begin
            cycle();
            chk("bp_hold_v", 512'(m_axi_cu_arvalid), 512'(1));
            chk("bp_hold_a", 512'(m_axi_cu_araddr), 512'(owners[0] == 1 ? a1 : a2));
            chk("bp_no_gnt", 512'(s_arready), 512'(0));
        end
        m_axi_cu_arready = 1'b1;
        #1;
        chk("bp_release", 512'(s_arready), 512'(owners[0] == 1 ? 4'b0100 : 4'b0010));
        drain();

        // R backpressure on an 8-beat burst from requester 3
        o3 = obs3;
        new_req(3);
        s_arlen[31:24] = 8'd7;
        n = 0;
        while (beat < 2 && n < 50) begin cycle(); n++; end
        chk("rbp_reach", 512'(beat), 512'(2));
        s_rready[3] = 1'b0;
        #1;
        chk("rbp_rready", 512'(m_axi_cu_rready), 512'(0));
        repeat (3) cycle();
        chk("rbp_beat", 512'(beat), 512'(2));
        s_rready[3] = 1'b1;
        drain();
        chk("rbp_beats", 512'(obs3 - o3), 512'(8));

        // R beat with nothing outstanding stalls
        r_hold = 1'b1;
        m_axi_cu_rvalid = 1'b1;
        m_axi_cu_rlast = 1'b1;
        repeat (3) cycle();
        chk("orphan_rready", 512'(m_axi_cu_rready), 512'(0));
        r_hold = 1'b0;
        m_axi_cu_rvalid = 1'b0;
        m_axi_cu_rlast = 1'b0;

        // random traffic
        len_max = 7;
        rnd = 1'b1;
        repeat (1500) cycle();
        s_arvalid = '0;
        drain();

        // reset during beat 2 of an 8-beat burst
        new_req(2);
        s_arlen[23:16] = 8'd7;
        n = 0;
        while (beat < 2 && n < 50) begin cycle(); n++; end
        reset_n = 1'b0;
        s_arvalid[0] = 1'b1;
        s_araddr[63:0] = 64'h2000;
        s_arlen[7:0] = 8'd0;
        #1;
        chk("mrst_arvalid", 512'(m_axi_cu_arvalid), 512'(0));
        chk("mrst_araddr", 512'(m_axi_cu_araddr), 512'(0));
        chk("mrst_arlen", 512'(m_axi_cu_arlen), 512'(0));
        chk("mrst_ost", 512'(ost_cnt), 512'(0));
        chk("mrst_arready", 512'(s_arready), 512'(0));
        chk("mrst_rvalid", 512'(s_rvalid), 512'(0));
        chk("mrst_rready", 512'(m_axi_cu_rready), 512'(0));
        model_reset();
        m_axi_cu_rvalid = 1'b0;
        m_axi_cu_rlast = 1'b0;
        @(posedge user_clk);
        @(posedge user_clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("mrst_regrant", 512'(s_arready), 512'(4'b0001));
        cycle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
